latch_bank_sched: RTL and testbench
===================================

Name: latch_bank_sched

Overview:
- Write scheduler for a bank of gated D latches with reset, of the kind built in the `d_latch_rst` lab.
- Shares the bank between several requesters using round-robin arbitration.
- Sequences each write as data setup, then a gate pulse, then data hold, so gate and data never change in the same cycle.
- Also issues a bank-wide latch reset on command. Sits between requester logic and the latch bank's d/clk/rst inputs.

Parameters:
NREQ, 4, number of requesters
NLAT, 8, number of latch words in the bank
DW, 8, data width per latch word
AW, 3, address width (NLAT <= 2**AW)
SETUP_CYC, 1, cycles lat_d is stable before the gate opens (>=1)
GATE_CYC, 2, cycles the gate, or lat_rst, is held high (>=1)
HOLD_CYC, 1, cycles lat_d is held after the gate closes (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NREQ  write request per requester, held until done
req_addr  in  NREQ*AW  target latch word per requester, requester i at bits [i*AW +: AW]
req_data  in  NREQ*DW  write data per requester, requester i at bits [i*DW +: DW]
clr_req  in  1  bank clear request, level, held until clr_done
gnt  out  NREQ  one-hot grant, high for the whole transaction
done  out  NREQ  one-cycle completion pulse to the granted requester
addr_err  out  1  one-cycle pulse with done when the address is >= NLAT
clr_done  out  1  one-cycle pulse at the end of a clear
lat_d  out  DW  data bus to the latch bank d inputs
lat_g  out  NLAT  per-word latch gate, at most one bit high
lat_rst  out  1  bank reset to the latches, active-high
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; RR pointer 0; all outputs 0 (gnt, done, addr_err, clr_done, lat_d, lat_g, lat_rst, busy). An in-flight transaction is abandoned with no done pulse.
- All outputs are registered.
- States: IDLE, SETUP, GATE, HOLD, DONE, CLR, CLR_DONE. A cycle counter sequences the multi-cycle states.
- IDLE, at a clock edge:
  - If clr_req=1, go to CLR. Clear has priority over all writes.
  - Else, if any req is high, grant index i = first requester with req high, searching ptr, ptr+1, ... mod NREQ.
  - On grant: gnt[i]=1, lat_d=req_data[i], address captured, go to SETUP. lat_g stays 0.
  - Address and data are sampled only at grant. Later changes to req_data or req_addr are ignored.
- SETUP: lasts SETUP_CYC cycles, then go to GATE.
- GATE: lat_g[addr]=1 for GATE_CYC cycles. If addr >= NLAT, lat_g stays all 0 and the flag is remembered.
- HOLD: lat_g=0, lat_d unchanged, for HOLD_CYC cycles, then go to DONE.
- DONE: one cycle.
  - done[i]=1; addr_err=1 if the flag was set.
  - At exit: gnt=0, lat_d=0, ptr=(i+1) mod NREQ, go to IDLE.
- CLR: lat_rst=1 for GATE_CYC cycles with lat_g=0, then go to CLR_DONE.
- CLR_DONE: one cycle, clr_done=1, lat_rst=0, then IDLE. ptr is unchanged.
- Timing with default parameters:
  - Grant registered at edge E0; lat_g high after E1 and E2; lat_g low after E3; done high after E4; IDLE after E5.
  - Earliest next grant is at E6, so back-to-back writes are spaced 6 cycles.
  - General grant-to-done = SETUP_CYC+GATE_CYC+HOLD_CYC cycles; done is high during the following cycle.
- Invariants:
  - lat_d never changes in a cycle where lat_g is nonzero, nor in the cycle where lat_g rises or falls.
  - lat_g and lat_rst are never high together.
  - gnt and lat_rst are never high together.
- Requests and clear:
  - A requester dropping req mid-transaction does not abort it; done still pulses.
  - clr_req raised mid-write waits until the write returns to IDLE.
  - A request held through done is eligible again, but RR places it last behind other pending requests.
- NREQ=1 degenerates to a plain sequencer. Simultaneous req and clr_req in IDLE: clear wins.

Test Plan:
- Reset, then req=0001, req_addr[0]=5, req_data[0]=8'hA5 → gnt=0001 next cycle; lat_g=8'h20 for exactly 2 cycles with lat_d=8'hA5; done[0] pulses 4 cycles after gnt rises; lat_d=8'hA5 from gnt rise through the done cycle, 0 after.
- req=1111 held continuously → grants in order 0,1,2,3,0 with 6-cycle spacing; no requester is granted twice before the others.
- clr_req=1 together with req=0010 in IDLE → lat_rst high 2 cycles, then clr_done pulse; then gnt=0010; lat_rst and lat_g never overlap.
- req_addr=7 versus req_addr=0 (NLAT=8): both write correctly. With NLAT=6 and addr=7 → lat_g stays 0 and addr_err pulses with done.
- rst driven low during GATE → all outputs 0 immediately, no done pulse; after release, a new req=0100 is granted (ptr=0 search).
- req_data changed and req dropped one cycle after grant → lat_d keeps the original value; done still pulses; no second transaction starts.

Source files
------------

// File: rtl/latch_bank_sched_if.sv
// Bundles the requester handshake and the latch-bank drive signals of latch_bank_sched.
// Latency: none, wiring only.
// Backpressure: req and clr_req are levels held by the requester until done/clr_done.
//
// Ports (master = requester/monitor side, slave = scheduler side):
//   req, req_addr, req_data, clr_req          requester -> scheduler
//   gnt, done, addr_err, clr_done, busy       scheduler -> requester
//   lat_d, lat_g, lat_rst                     scheduler -> latch bank
interface latch_bank_sched_if #(
    parameter int NREQ = 4,
    parameter int NLAT = 8,
    parameter int DW   = 8,
    parameter int AW   = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               clr_req;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               addr_err;
    logic               clr_done;
    logic [DW-1:0]      lat_d;
    logic [NLAT-1:0]    lat_g;
    logic               lat_rst;
    logic               busy;

    modport master (
        output req, req_addr, req_data, clr_req,
        input  gnt, done, addr_err, clr_done, lat_d, lat_g, lat_rst, busy
    );

    modport slave (
        input  req, req_addr, req_data, clr_req,
        output gnt, done, addr_err, clr_done, lat_d, lat_g, lat_rst, busy
    );
endinterface

// File: rtl/latch_bank_sched.sv
// Round-robin write scheduler for a bank of gated D latches, plus a bank-wide clear.
// Latency: grant to done = SETUP_CYC+GATE_CYC+HOLD_CYC cycles; one idle cycle follows done.
// Backpressure: requesters hold req until their done pulse; clr_req is held until clr_done.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   bus      latch_bank_sched_if.slave: requests/clear in, grant/done/latch drive out
module latch_bank_sched #(
    parameter int NREQ      = 4,
    parameter int NLAT      = 8,
    parameter int DW        = 8,
    parameter int AW        = 3,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    latch_bank_sched_if.slave  bus
);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (SETUP_CYC > GATE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((GATE_CYC > HOLD_CYC) ? GATE_CYC : HOLD_CYC);
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, GATE, HOLD, DONE, CLR, CLR_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            addr_err_q, addr_err_d;
    logic            clr_done_q, clr_done_d;
    logic [DW-1:0]   lat_d_q, lat_d_d;
    logic [NLAT-1:0] lat_g_q, lat_g_d;
    logic            lat_rst_q, lat_rst_d;
    logic            busy_q, busy_d;

    // Round-robin pick: first requester at or after ptr, wrapping.
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_vld && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        addr_d     = addr_q;
        err_d      = err_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        addr_err_d = 1'b0;
        clr_done_d = 1'b0;
        lat_d_d    = lat_d_q;
        lat_g_d    = lat_g_q;
        lat_rst_d  = lat_rst_q;

        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d   = CLR;
                    cnt_d     = CW'(GATE_CYC - 1);
                    lat_rst_d = 1'b1;
                end else if (pick_vld) begin
                    // Address and data are captured here and never re-sampled.
                    state_d = SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    gidx_d  = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    addr_d  = bus.req_addr[int'(pick_idx)*AW +: AW];
                    lat_d_d = bus.req_data[int'(pick_idx)*DW +: DW];
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = GATE;
                    cnt_d   = CW'(GATE_CYC - 1);
                    // Out-of-range words get no gate; the error is reported with done.
                    if (int'(addr_q) < NLAT) begin
                        lat_g_d = NLAT'(1) << addr_q;
                        err_d   = 1'b0;
                    end else begin
                        lat_g_d = '0;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GATE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    lat_g_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    done_d     = NREQ'(1) << gidx_q;
                    addr_err_d = err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                lat_d_d = '0;
                ptr_d   = IW'((int'(gidx_q) + 1) % NREQ);
            end
            CLR: begin
                if (cnt_q == '0) begin
                    state_d    = CLR_DONE;
                    lat_rst_d  = 1'b0;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CLR_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gidx_q     <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            addr_err_q <= 1'b0;
            clr_done_q <= 1'b0;
            lat_d_q    <= '0;
            lat_g_q    <= '0;
            lat_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
            clr_done_q <= clr_done_d;
            lat_d_q    <= lat_d_d;
            lat_g_q    <= lat_g_d;
            lat_rst_q  <= lat_rst_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.addr_err = addr_err_q;
    assign bus.clr_done = clr_done_q;
    assign bus.lat_d    = lat_d_q;
    assign bus.lat_g    = lat_g_q;
    assign bus.lat_rst  = lat_rst_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_latch_bank_sched.sv
// Bench for latch_bank_sched: two instances (8 and 6 latch words) share one stimulus stream.
// Latency: outputs compared every cycle on the falling edge against a transaction-timeline model.
// Backpressure: bench requesters hold req until done and clr_req until clr_done (or drop early on purpose).
module tb_latch_bank_sched;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int S    = 1;
    localparam int G    = 2;
    localparam int H    = 1;
    localparam int L    = S + G + H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    latch_bank_sched_if #(.NREQ(NREQ), .NLAT(8), .DW(DW), .AW(AW)) ifc ();
    latch_bank_sched_if #(.NREQ(NREQ), .NLAT(6), .DW(DW), .AW(AW)) ifc6 ();

    assign ifc6.req      = ifc.req;
    assign ifc6.req_addr = ifc.req_addr;
    assign ifc6.req_data = ifc.req_data;
    assign ifc6.clr_req  = ifc.clr_req;

    latch_bank_sched #(.NREQ(NREQ), .NLAT(8), .DW(DW), .AW(AW),
                       .SETUP_CYC(S), .GATE_CYC(G), .HOLD_CYC(H))
        dut (.clk(clk), .rst(rst), .bus(ifc));

    latch_bank_sched #(.NREQ(NREQ), .NLAT(6), .DW(DW), .AW(AW),
                       .SETUP_CYC(S), .GATE_CYC(G), .HOLD_CYC(H))
        dut6 (.clk(clk), .rst(rst), .bus(ifc6));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: a transaction is a timeline; t counts edges since it started.
    typedef enum int {M_IDLE, M_WR, M_CLR} mmode_t;
    mmode_t     m_mode = M_IDLE;
    int         m_t    = 0;
    int         m_gi   = 0;
    int         m_ptr  = 0;
    int         m_addr = 0;
    logic [7:0] m_data = '0;

    int   grant_idx[$];
    int   grant_cyc[$];
    int   gnt0_cyc  = 0;
    int   done0_cyc = 0;
    int   g20_cnt   = 0;
    bit   ae6_seen  = 0;
    bit   ae8_seen  = 0;
    logic [NREQ-1:0] gnt_prev  = '0;
    logic [NREQ-1:0] done_prev = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_t    = 0;
        m_ptr  = 0;
    endtask

    task automatic model_step();
        if (m_mode == M_IDLE) begin
            if (ifc.clr_req) begin
                m_mode = M_CLR;
                m_t    = 1;
            end else if (ifc.req != '0) begin
                for (int k = NREQ - 1; k >= 0; k--)
                    if (ifc.req[(m_ptr + k) % NREQ]) m_gi = (m_ptr + k) % NREQ;
                m_mode = M_WR;
                m_t    = 1;
                m_data = ifc.req_data[m_gi*DW +: DW];
                m_addr = int'(ifc.req_addr[m_gi*AW +: AW]);
            end
        end else begin
            m_t++;
            if (m_mode == M_WR && m_t == L + 2) begin
                m_mode = M_IDLE;
                m_ptr  = (m_gi + 1) % NREQ;
            end else if (m_mode == M_CLR && m_t == G + 2) begin
                m_mode = M_IDLE;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] e_gnt, e_done, e_d, e_g8, e_g6;
        logic        wr, in_gate, at_done;
        wr      = (m_mode == M_WR);
        in_gate = wr && m_t >= S + 1 && m_t <= S + G;
        at_done = wr && m_t == L + 1;
        e_gnt   = wr ? (32'd1 << m_gi) : 32'd0;
        e_done  = at_done ? (32'd1 << m_gi) : 32'd0;
        e_d     = wr ? 32'(m_data) : 32'd0;
        e_g8    = (in_gate && m_addr < 8) ? (32'd1 << m_addr) : 32'd0;
        e_g6    = (in_gate && m_addr < 6) ? (32'd1 << m_addr) : 32'd0;
        chk("gnt",       32'(ifc.gnt),      e_gnt);
        chk("done",      32'(ifc.done),     e_done);
        chk("lat_d",     32'(ifc.lat_d),    e_d);
        chk("lat_g",     32'(ifc.lat_g),    e_g8);
        chk("addr_err",  32'(ifc.addr_err), 32'(at_done && m_addr >= 8));
        chk("lat_rst",   32'(ifc.lat_rst),  32'(m_mode == M_CLR && m_t <= G));
        chk("clr_done",  32'(ifc.clr_done), 32'(m_mode == M_CLR && m_t == G + 1));
        chk("busy",      32'(ifc.busy),     32'(m_mode != M_IDLE));
        chk("n6_gnt",    32'(ifc6.gnt),     e_gnt);
        chk("n6_lat_g",  32'(ifc6.lat_g),   e_g6);
        chk("n6_addr_err", 32'(ifc6.addr_err), 32'(at_done && m_addr >= 6));
        chk("n6_lat_d",  32'(ifc6.lat_d),   e_d);
    endtask

    task automatic observe();
        if (ifc.gnt != '0 && gnt_prev == '0) begin
            for (int i = 0; i < NREQ; i++)
                if (ifc.gnt[i]) begin
                    grant_idx.push_back(i);
                    grant_cyc.push_back(cyc);
                end
        end
        if (ifc.gnt[0] && !gnt_prev[0])   gnt0_cyc  = cyc;
        if (ifc.done[0] && !done_prev[0]) done0_cyc = cyc;
        if (ifc.lat_g == 8'h20) g20_cnt++;
        if (ifc6.addr_err) ae6_seen = 1;
        if (ifc.addr_err)  ae8_seen = 1;
        gnt_prev  = ifc.gnt;
        done_prev = ifc.done;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        cyc++;
        @(negedge clk);
        check_all();
        observe();
    endtask

    task automatic wait_done(input int i);
        bit seen = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            cycle();
            if (ifc.done[i]) seen = 1;
        end
        if (!seen) chk("timeout_done", 32'd0, 32'd1);
        ifc.req[i] = 1'b0;
    endtask

    task automatic wait_clr_done();
        bit seen = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            cycle();
            if (ifc.clr_done) seen = 1;
        end
        if (!seen) chk("timeout_clr", 32'd0, 32'd1);
        ifc.clr_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_mode != M_IDLE && n < 60) begin
            cycle();
            n++;
        end
        if (m_mode != M_IDLE) chk("timeout_idle", 32'd0, 32'd1);
        cycle();
    endtask

    task automatic set_req(input int i, input int a, input logic [7:0] d);
        ifc.req_addr[i*AW +: AW] = AW'(a);
        ifc.req_data[i*DW +: DW] = d;
        ifc.req[i]               = 1'b1;
    endtask

    initial begin
        int n0;
        ifc.req      = '0;
        ifc.req_addr = '0;
        ifc.req_data = '0;
        ifc.clr_req  = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // Round robin with all four requesting.
        grant_idx.delete();
        grant_cyc.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, i, 8'(8'h10 + i));
        for (int n = 0; n < 60 && grant_idx.size() < 5; n++) cycle();
        ifc.req = '0;
        wait_idle();
        chk("rr_count", 32'(grant_idx.size()), 32'd5);
        for (int k = 0; k < grant_idx.size() && k < 5; k++) begin
            chk("rr_order", 32'(grant_idx[k]), 32'(k % NREQ));
            if (k > 0) chk("rr_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd6);
        end

        // Single write to word 5.
        g20_cnt = 0;
        set_req(0, 5, 8'hA5);
        wait_done(0);
        wait_idle();
        chk("gnt_to_done", 32'(done0_cyc - gnt0_cyc), 32'd4);
        chk("gate_cycles", 32'(g20_cnt), 32'd2);

        // Clear and a write raised together: clear first.
        set_req(1, 2, 8'h3C);
        ifc.clr_req = 1'b1;
        n0 = grant_idx.size();
        wait_clr_done();
        chk("clr_first_no_grant", 32'(grant_idx.size() - n0), 32'd0);
        wait_done(1);
        wait_idle();

        // Highest and lowest addresses; word 7 is out of range for the 6-word bank.
        ae6_seen = 0;
        ae8_seen = 0;
        set_req(2, 7, 8'h77);
        wait_done(2);
        wait_idle();
        set_req(3, 0, 8'h00);
        wait_done(3);
        wait_idle();
        chk("ae6_seen", 32'(ae6_seen), 32'd1);
        chk("ae8_seen", 32'(ae8_seen), 32'd0);

        // Reset asserted while the gate is open.
        set_req(0, 3, 8'h5A);
        for (int n = 0; n < 20 && !(m_mode == M_WR && m_t == S + 1); n++) cycle();
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst_lat_g_now", 32'(ifc.lat_g), 32'd0);
        ifc.req = '0;
        cycle();
        cycle();
        chk("rst_no_done", 32'(ifc.done), 32'd0);
        rst = 1'b1;
        set_req(2, 1, 8'hC3);
        cycle();
        chk("post_rst_gnt", 32'(ifc.gnt), 32'b0100);
        wait_done(2);
        wait_idle();

        // Data changed and request dropped right after grant.
        set_req(0, 2, 8'h3C);
        n0 = grant_idx.size();
        cycle();
        ifc.req_data[0 +: DW] = 8'hFF;
        ifc.req_addr[0 +: AW] = 3'd6;
        ifc.req = '0;
        cycle();
        chk("held_lat_d", 32'(ifc.lat_d), 32'h3C);
        wait_idle();
        cycle();
        cycle();
        chk("single_txn", 32'(grant_idx.size() - n0), 32'd1);

        // Randomised traffic with clears and early request drops.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!ifc.req[i]) begin
                    if ($urandom_range(3) == 0) set_req(i, $urandom_range(7), 8'($urandom));
                end else if (ifc.done[i]) begin
                    if ($urandom_range(1) == 0) ifc.req[i] = 1'b0;
                end else if ($urandom_range(31) == 0) begin
                    ifc.req[i] = 1'b0;
                end
                if ($urandom_range(7) == 0) ifc.req_data[i*DW +: DW] = 8'($urandom);
            end
            if (ifc.clr_req && ifc.clr_done)                 ifc.clr_req = 1'b0;
            else if (!ifc.clr_req && $urandom_range(39) == 0) ifc.clr_req = 1'b1;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
